// File: rtl/b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if.sv
// Single valid/ready channel carrying one payload beat per handshake.
// The master drives data/valid; the slave drives ready.
interface b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/b_io_l3_in_serialize_b_m_axi_reg_slice_pipe.sv
// Chain of STAGES register slices on one valid/ready channel, with synchronous flush and
// a beat occupancy count. MODE selects full skid, forward-only or bypass stages.
module b_io_l3_in_serialize_b_m_axi_reg_slice_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned MODE       = 0,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             flush,
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if.slave     s,
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if.master    m,
    output logic [CNT_WIDTH-1:0]                             count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} stage_e;

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $fatal(1, "STAGES must be in 1..8");
    end
    if (MODE > 2) begin : g_bad_mode
        $fatal(1, "MODE must be 0, 1 or 2");
    end
    if ((2 ** CNT_WIDTH) <= (2 * STAGES)) begin : g_bad_cnt
        $fatal(1, "CNT_WIDTH too small for 2*STAGES");
    end

    if (MODE == 2) begin : g_bypass
        assign m.data  = s.data;
        assign m.valid = s.valid;
        assign s.ready = m.ready;
        assign count   = '0;
    end else begin : g_pipe
        // Forward stages gate ready one edge later so both modes release on the same edge.
        localparam int unsigned LIVE_W = (MODE == 1) ? 2 : 1;

        logic [LIVE_W-1:0]     r_live;
        logic                  w_live;
        logic [CNT_WIDTH-1:0]  r_count;
        logic                  w_s_acc;
        logic                  w_m_acc;
        logic [DATA_WIDTH-1:0] w_dat [STAGES+1];
        logic [STAGES:0]       w_vld;
        logic [STAGES:0]       w_rdy;

        assign w_live         = r_live[LIVE_W-1];
        assign w_dat[0]       = s.data;
        assign w_vld[0]       = s.valid;
        assign s.ready        = w_rdy[0];
        assign m.data         = w_dat[STAGES];
        assign m.valid        = w_vld[STAGES];
        assign w_rdy[STAGES]  = m.ready;
        assign w_s_acc        = w_vld[0] & w_rdy[0];
        assign w_m_acc        = w_vld[STAGES] & m.ready;
        assign count          = r_count;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_live  <= '0;
                r_count <= '0;
            end else begin
                r_live <= (r_live << 1) | LIVE_W'(1);
                if (flush) begin
                    r_count <= '0;
                end else if (w_s_acc && !w_m_acc) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end else if (!w_s_acc && w_m_acc) begin
                    r_count <= r_count - CNT_WIDTH'(1);
                end
            end
        end

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (MODE == 0) begin : g_full
                stage_e                r_state;
                logic                  r_vld;
                logic                  r_rdy;
                logic [DATA_WIDTH-1:0] r_dat;
                logic [DATA_WIDTH-1:0] r_skid;
                logic                  w_in_acc;
                logic                  w_out_acc;

                assign w_in_acc   = w_vld[i] & r_rdy;
                assign w_out_acc  = r_vld & w_rdy[i+1];
                assign w_vld[i+1] = r_vld;
                assign w_dat[i+1] = r_dat;
                assign w_rdy[i]   = r_rdy;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_state <= StEmpty;
                        r_vld   <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_dat   <= '0;
                        r_skid  <= '0;
                    end else if (flush) begin
                        r_state <= StEmpty;
                        r_vld   <= 1'b0;
                        r_rdy   <= w_live;
                    end else begin
                        unique case (r_state)
                            StEmpty: begin
                                r_rdy <= w_live;
                                if (w_in_acc) begin
                                    r_state <= StOne;
                                    r_vld   <= 1'b1;
                                    r_dat   <= w_dat[i];
                                end
                            end
                            StOne: begin
                                if (w_in_acc && !w_out_acc) begin
                                    r_state <= StFull;
                                    r_skid  <= w_dat[i];
                                    r_rdy   <= 1'b0;
                                end else begin
                                    if (w_in_acc) begin
                                        r_dat <= w_dat[i];
                                    end else if (w_out_acc) begin
                                        r_state <= StEmpty;
                                        r_vld   <= 1'b0;
                                    end
                                    r_rdy <= w_live;
                                end
                            end
                            StFull: begin
                                if (w_out_acc) begin
                                    r_state <= StOne;
                                    r_dat   <= r_skid;
                                    r_rdy   <= w_live;
                                end
                            end
                            default: r_state <= StEmpty;
                        endcase
                    end
                end
            end else begin : g_fwd
                logic                  r_vld;
                logic [DATA_WIDTH-1:0] r_dat;

                // Ready flattened: a stage can take a beat if any stage at or after it has room.
                if (i == 0) begin : g_head
                    assign w_rdy[i] = w_live & (m.ready | ~(&w_vld[STAGES:i+1]));
                end else begin : g_body
                    assign w_rdy[i] = m.ready | ~(&w_vld[STAGES:i+1]);
                end
                assign w_vld[i+1] = r_vld;
                assign w_dat[i+1] = r_dat;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_vld <= 1'b0;
                        r_dat <= '0;
                    end else if (flush) begin
                        r_vld <= 1'b0;
                    end else if (w_rdy[i]) begin
                        r_vld <= w_vld[i];
                        if (w_vld[i]) begin
                            r_dat <= w_dat[i];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_reg_slice_pipe.sv
// Scoreboard bench: directed MODE0/STAGES=2 scenarios, randomized traffic on four
// MODE/STAGES configurations, and a bypass instance.
module tb_b_io_l3_in_serialize_b_m_axi_reg_slice_pipe;

    localparam int unsigned DW = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- directed instance: MODE 0, STAGES 2 ----------------
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) a_s ();
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) a_m ();
    logic       a_flush = 1'b0;
    logic [4:0] a_count;

    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe #(
        .DATA_WIDTH(DW), .STAGES(2), .MODE(0), .CNT_WIDTH(5)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush), .s(a_s), .m(a_m), .count(a_count)
    );

    logic [7:0] qa[$];
    bit         a_hold = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            qa.delete();
            a_hold = 1'b0;
        end else begin
            chk_eq("a_count_model", a_count, qa.size());
            if (a_hold) chk_eq("a_valid_held", a_m.valid, 1);
            if (a_m.valid && a_m.ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_beat: got data %0d, expected no beat", a_m.data);
                end else begin
                    chk_eq("a_data_order", a_m.data, qa.pop_front());
                end
            end
            if (a_flush) qa.delete();
            else if (a_s.valid && a_s.ready) qa.push_back(a_s.data);
            a_hold = a_m.valid && !a_m.ready && !a_flush;
        end
    end

    task automatic drain_a(input string name);
        int n = 0;
        a_m.ready = 1'b1;
        while ((qa.size() != 0 || a_m.valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq({name, "_drain_in_time"}, int'(n < 100), 1);
        chk_eq({name, "_count_zero"}, a_count, 0);
    endtask

    // ---------------- bypass instance: MODE 2 ----------------
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) e_s ();
    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) e_m ();
    logic       e_flush = 1'b0;
    logic [4:0] e_count;

    b_io_l3_in_serialize_b_m_axi_reg_slice_pipe #(
        .DATA_WIDTH(DW), .STAGES(2), .MODE(2), .CNT_WIDTH(5)
    ) u_e (
        .clk(clk), .reset_n(reset_n), .flush(e_flush), .s(e_s), .m(e_m), .count(e_count)
    );

    // ---------------- randomized instances: MODE 0/1 x STAGES 1/3 ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int unsigned RM  = g % 2;
        localparam int unsigned RS  = (g / 2 == 0) ? 1 : 3;
        localparam int unsigned CAP = (RM == 0) ? 2 * RS : RS;

        b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) r_s ();
        b_io_l3_in_serialize_b_m_axi_reg_slice_pipe_if #(.DATA_WIDTH(DW)) r_m ();
        logic [4:0] r_count;
        logic [7:0] q[$];
        bit         done     = 1'b0;
        bit         hold     = 1'b0;
        int         accepted = 0;

        b_io_l3_in_serialize_b_m_axi_reg_slice_pipe #(
            .DATA_WIDTH(DW), .STAGES(RS), .MODE(RM), .CNT_WIDTH(5)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .flush(1'b0), .s(r_s), .m(r_m), .count(r_count)
        );

        always @(negedge clk) begin
            if (reset_n) begin
                chk_eq($sformatf("rnd%0d_count_model", g), r_count, q.size());
                chk_eq($sformatf("rnd%0d_within_capacity", g), int'(r_count <= CAP), 1);
                if (hold) chk_eq($sformatf("rnd%0d_valid_held", g), r_m.valid, 1);
                if (r_m.valid && r_m.ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd%0d_unexpected_beat: got data %0d, expected no beat",
                                 g, r_m.data);
                    end else begin
                        chk_eq($sformatf("rnd%0d_data_order", g), r_m.data, q.pop_front());
                    end
                end
                if (r_s.valid && r_s.ready) begin
                    q.push_back(r_s.data);
                    accepted++;
                end
                hold = r_m.valid && !r_m.ready;
            end
        end

        initial begin
            bit took = 1'b0;
            int n    = 0;
            r_s.valid = 1'b0;
            r_s.data  = '0;
            r_m.ready = 1'b1;
            @(posedge reset_n);
            @(posedge clk);
            #1;
            chk_eq($sformatf("rnd%0d_release_edge1_ready", g), r_s.ready, 0);
            @(posedge clk);
            #1;
            chk_eq($sformatf("rnd%0d_release_edge2_ready", g), r_s.ready, 1);
            while (accepted < 1000 && n < 20000) begin
                if (!r_s.valid || took) begin
                    r_s.valid = 1'($urandom_range(0, 1));
                    r_s.data  = 8'($urandom);
                end
                r_m.ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                took = r_s.valid && r_s.ready;
                @(posedge clk);
                #1;
                n++;
            end
            r_m.ready = 1'b1;
            if (took) r_s.valid = 1'b0;
            n = 0;
            while ((r_s.valid || q.size() != 0 || r_m.valid) && n < 200) begin
                @(negedge clk);
                took = r_s.valid && r_s.ready;
                @(posedge clk);
                #1;
                if (took) r_s.valid = 1'b0;
                n++;
            end
            chk_eq($sformatf("rnd%0d_beats_accepted", g), int'(accepted >= 1000), 1);
            chk_eq($sformatf("rnd%0d_drained", g), q.size(), 0);
            chk_eq($sformatf("rnd%0d_count_zero", g), r_count, 0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int t;
        a_s.valid = 1'b0;
        a_s.data  = '0;
        a_m.ready = 1'b0;
        e_s.valid = 1'b0;
        e_s.data  = '0;
        e_m.ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("reset_s_ready", a_s.ready, 0);
        chk_eq("reset_m_valid", a_m.valid, 0);
        chk_eq("reset_count", a_count, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("release_edge1_s_ready", a_s.ready, 0);
        @(posedge clk);
        #1;
        chk_eq("release_edge2_s_ready", a_s.ready, 1);
        chk_eq("release_m_valid", a_m.valid, 0);
        chk_eq("release_count", a_count, 0);

        // Streaming: beat i+1 is offered in iteration i; beat 1 shows after two edges.
        a_m.ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_s.valid = 1'b1;
            a_s.data  = 8'(i + 1);
            @(negedge clk);
            chk_eq("stream_s_ready", a_s.ready, 1);
            if (i == 1) chk_eq("stream_latency_not_early", a_m.valid, 0);
            if (i >= 2) begin
                chk_eq("stream_m_valid", a_m.valid, 1);
                chk_eq("stream_m_data", a_m.data, i - 1);
                chk_eq("stream_count", a_count, 2);
            end
            @(posedge clk);
            #1;
        end
        a_s.valid = 1'b0;
        drain_a("stream");

        // Backpressure: capacity is four beats.
        a_m.ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            a_s.valid = (k < 6);
            a_s.data  = 8'(k + 1);
            @(negedge clk);
            if (a_s.valid && a_s.ready) k++;
            @(posedge clk);
            #1;
        end
        chk_eq("bp_accepted", k, 4);
        chk_eq("bp_s_ready", a_s.ready, 0);
        chk_eq("bp_count", a_count, 4);
        a_m.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a_s.valid = (k < 6);
            a_s.data  = 8'(k + 1);
            @(negedge clk);
            chk_eq("bp_no_gap", a_m.valid, 1);
            chk_eq("bp_out_data", a_m.data, c + 1);
            if (a_s.valid && a_s.ready) k++;
            @(posedge clk);
            #1;
        end
        a_s.valid = 1'b0;
        chk_eq("bp_all_accepted", k, 6);
        drain_a("bp");

        // Flush with three beats held and 0xAA handshaking on the flush edge.
        a_m.ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            a_s.valid = 1'b1;
            a_s.data  = 8'(8'h31 + j);
            @(posedge clk);
            #1;
        end
        a_s.valid = 1'b0;
        chk_eq("flush_fill_count", a_count, 3);
        a_flush   = 1'b1;
        a_s.valid = 1'b1;
        a_s.data  = 8'hAA;
        @(posedge clk);
        #1;
        a_flush   = 1'b0;
        a_s.valid = 1'b0;
        chk_eq("flush_m_valid", a_m.valid, 0);
        chk_eq("flush_count", a_count, 0);
        chk_eq("flush_s_ready", a_s.ready, 1);
        a_flush   = 1'b1;
        a_s.valid = 1'b1;
        a_s.data  = 8'hBB;
        a_m.ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            chk_eq("flush_held_count", a_count, 0);
            chk_eq("flush_held_m_valid", a_m.valid, 0);
        end
        a_flush   = 1'b0;
        a_s.valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            a_s.valid = 1'b1;
            a_s.data  = 8'(8'h41 + j);
            @(posedge clk);
            #1;
        end
        a_s.valid = 1'b0;
        drain_a("restart");

        // Bypass: combinational pass-through, flush ignored, count constant zero.
        for (int i = 0; i < 16; i++) begin
            e_s.valid = 1'($urandom_range(0, 1));
            e_s.data  = 8'($urandom);
            e_m.ready = 1'($urandom_range(0, 1));
            e_flush   = 1'($urandom_range(0, 1));
            #2;
            chk_eq("bypass_s_ready", e_s.ready, e_m.ready);
            chk_eq("bypass_m_valid", e_m.valid, e_s.valid);
            chk_eq("bypass_m_data", e_m.data, e_s.data);
            chk_eq("bypass_count", e_count, 0);
        end

        t = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done)
               && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk_eq("random_runs_finished", int'(t < 60000), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/b_io_l3_in_serialize_b_m_axi_reg_slice_pipe.md
Name: b_io_l3_in_serialize_b_m_axi_reg_slice_pipe

Overview:
Parametrised chain of AXI-channel register slices for the m_axi datapath of the serialize_B IO module. It inserts STAGES pipeline stages on one valid/ready channel, with a selectable stage type. It adds two features the single-stage slice lacks: a synchronous flush and an occupancy count. It sits between the AXI read/write channel logic and the bus adapter, so long routes can be retimed without losing throughput.

Parameters:
DATA_WIDTH, 8, payload width in bits.
STAGES, 2, number of slice stages in series; legal range 1..8.
MODE, 0, stage type: 0 = full (two-entry skid, all outputs registered); 1 = forward (one-entry, valid/data registered, ready combinational); 2 = bypass (wires).
CNT_WIDTH, 5, occupancy counter width; must satisfy 2^CNT_WIDTH > 2*STAGES.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all stored beats.
s_data  input  DATA_WIDTH  upstream payload.
s_valid  input  1  upstream valid.
s_ready  output  1  upstream ready.
m_data  output  DATA_WIDTH  downstream payload.
m_valid  output  1  downstream valid.
m_ready  input  1  downstream ready.
count  output  CNT_WIDTH  beats currently held in the chain.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0: every stage empty, m_valid=0, s_ready=0, count=0.
- Reset release (MODE 0): s_ready stays 0 in the first clk edge after release and rises on the second edge. MODE 1 follows the same rule.
- Handshake: a beat transfers on an edge where valid&ready=1. Once asserted, valid and data are held until accepted. No beat is dropped, duplicated or reordered, except by flush.
- MODE 0 stage states are EMPTY (0 beats), ONE (1 beat, out valid) and FULL (2 beats, in-ready low).
  - EMPTY -> ONE on input accept.
  - ONE -> EMPTY on output accept with no input.
  - ONE -> FULL on input with output stalled.
  - ONE stays ONE on simultaneous input and output accept.
  - FULL -> ONE on output accept; the skid entry moves to the output register.
  - The stage's in-ready is registered: it is 1 in EMPTY and ONE and 0 in FULL. It updates the edge after the transition.
- MODE 0 timing:
  - Latency: a beat accepted at edge N appears on m_valid after edge N+STAGES-1, i.e. it is visible from cycle N+1 for STAGES=1.
  - Throughput: 1 beat/clk sustained with m_ready=1.
  - Capacity: 2*STAGES beats.
  - m_valid, m_data and s_ready are driven from flops only.
- MODE 1 stage behaviour:
  - Single register per stage.
  - Stage in-ready = ~stage_valid | out_ready, combinational.
  - Latency: STAGES cycles. Capacity: STAGES beats. Throughput: 1/clk.
  - A combinational ready path exists end to end.
- MODE 2: m_data=s_data, m_valid=s_valid, s_ready=m_ready, count=0 constant. flush is ignored. No flops are used.
- Flush (MODES 0/1):
  - When flush=1 at an edge, all stages go EMPTY and count goes to 0.
  - A beat handshaken at s during that edge is discarded.
  - A beat accepted at m during that edge is counted as delivered.
  - Next cycle: m_valid=0. s_ready=1 (MODE 0 registered ready goes 1 at that edge).
  - flush held high keeps the chain empty.
- count:
  - Increments on s accept, decrements on m accept, unchanged when both or neither occur.
  - Registered, and updated at the same edge as the state.
  - Never exceeds the capacity and never underflows.
- Simultaneous events:
  - Asynchronous reset overrides flush and handshakes.
  - Reset asserted mid-burst empties the chain immediately (asynchronously). No partial beat emerges after release.
- Illegal parameters (STAGES=0, MODE>2, CNT_WIDTH too small) must fail elaboration.

Test Plan:
- Reset, MODE0, STAGES=2: reset_n low for 3 clk, release -> s_ready=0 on the first edge after release, 1 from the second edge; m_valid=0, count=0.
- Streaming, MODE0, STAGES=2: drive 0x01..0x10 with s_valid=1, m_ready=1 -> m_data is 0x01..0x10 in order, one per clk after the 2-cycle latency; count steady at 2; s_ready never drops.
- Backpressure: m_ready=0, stream 0x01..0x06 -> exactly 4 accepted, s_ready=0, count=4. Then m_ready=1 -> outputs 0x01..0x06 with no gaps, count returns to 0.
- Random ready/valid: 50% m_ready and s_valid over 1000 beats, MODE 0 and MODE 1, STAGES=1 and 3 -> scoreboard matches in order, count equals the model.
- Flush: fill to count=3, pulse flush with s_valid=1 and s_data=0xAA -> next cycle m_valid=0, count=0; 0xAA never appears; the stream restarts cleanly.
- Bypass, MODE2: toggle m_ready and s_valid -> s_ready=m_ready, m_data=s_data in the same cycle, count=0; flush has no effect.
